red_pitaya_dac_slew_lim: RTL and testbench
==========================================

// Module: red_pitaya_dac_slew_lim
// PURPOSE
//  Output conditioning stage between the ASG per-channel sample stream (dac_a/dac_b)
//  and the DAC interface; one instance per channel.
//  - Clamps each sample to a programmable window.
//  - Limits per-cycle sample change to a programmable slew step.
//  - On disable, ramps the output to 0 at the slew rate instead of stepping.
//  - Reports sticky clip status to the register bank.
// PARAMETERS
//  DW   14  sample width, signed two's complement, in and out
// PORTS
//  dac_clk_i    in   1   DAC clock 125 MHz; sole clock
//  dac_rst_i    in   1   reset, synchronous, active-high
//  dat_i        in   DW  signed sample from ASG, valid every cycle
//  enable_i     in   1   1 = track dat_i; 1->0 starts ramp-down
//  slew_step_i  in   DW  unsigned max |change|/cycle; 0 = limiting bypassed
//  clip_hi_i    in   DW  signed upper clamp bound
//  clip_lo_i    in   DW  signed lower clamp bound
//  clr_i        in   1   1-cycle pulse, clears clip_o
//  dac_o        out  DW  signed conditioned sample to DAC formatter
//  active_o     out  1   1 in RUN or STOP state
//  slewing_o    out  1   1 when the current dac_o update was step-limited
//  clip_o       out  1   sticky: a sample was clamped since last clr_i
// BEHAVIOUR
//  Reset: dac_o=0, active_o=0, slewing_o=0, clip_o=0, state=IDLE, pipe regs=0.
//  Stage 1 (reg): tgt = clamp(dat_i): if dat_i<lo then lo; then if >hi then hi.
//   - All compares are signed.
//   - If lo>hi the result is hi (hi wins).
//   - clip_ev=1 when tgt!=dat_i.
//  Stage 2 (reg): diff = tgt_eff - dac_o, computed in DW+1 bits, no overflow.
//   - step==0 or |diff|<=step: dac_o<=tgt_eff, slewing_o<=0.
//   - Otherwise dac_o<=dac_o+sign(diff)*step, slewing_o<=1.
//   - Result always lies between old dac_o and tgt_eff; never wraps.
//  Latency: dat_i -> dac_o = 2 cycles when unlimited. Config inputs are used live, not latched.
//  FSM (state reg):
//   - IDLE: tgt_eff=0, dac_o held 0. enable_i=1 -> RUN.
//   - RUN: tgt_eff=tgt. enable_i=0 -> STOP.
//   - STOP: tgt_eff=0, slew applies. enable_i=1 -> RUN, resuming tracking from the current dac_o, no jump.
//     Leaves STOP when dac_o==0 at the cycle start -> IDLE.
//     step==0 forces dac_o=0 next cycle, then IDLE.
//  active_o = registered (state!=IDLE).
//  clip_o: set by clip_ev only while in RUN; cleared by clr_i; clr_i and clip_ev in the same cycle -> 1 (set wins).
//  Reset mid-ramp: all state returns to reset values on the next edge; dac_o=0 immediately, no ramp.
//  Extremes: dat_i=-2^(DW-1), clip window full range, step=2^DW-1 -> no overflow, output exact.
// STRUCTURE
//  Package red_pitaya_dac_pkg:
//   - typedef enum logic[1:0] {IDLE,RUN,STOP} slew_state_t
//   - localparam DAC_DW=14
//   - function sat_clamp(signed x, lo, hi)
//  Sub-module red_pitaya_dac_clip: stage-1 clamp register plus clip_ev.
//  FSM and slew arithmetic live in the top.
//  Top-level instantiates two copies between asg dac_a_o/dac_b_o and the DAC formatter.
// TESTING
//  1 Bypass: step=0, lo=-8192, hi=8191, enable=1, dat_i 3,30,8000,-4
//    -> same values on dac_o 2 cycles later; slewing_o=0; clip_o=0.
//  2 Clamp: hi=2000, lo=-2000, dat_i=8000 then -8000
//    -> dac_o 2000 then -2000; clip_o=1 stays 1; clr_i -> 0.
//    clr_i same cycle as clamp -> clip_o stays 1.
//  3 Slew: step=100, dac_o=0, dat_i step to 1050
//    -> dac_o 100,200,...,1000,1050; slewing_o=1 for the first 10 updates, then 0.
//  4 Ramp-down: step=250, dac_o=1000, enable 1->0
//    -> dac_o 750,500,250,0; active_o falls 1 cycle after 0 reached.
//    enable 1->0->1 at dac_o=500 -> ramps back toward dat_i from 500.
//  5 Inverted window and extremes: lo=100, hi=-100 -> dac_o=-100.
//    step=16383, dat_i -8192 <-> 8191 alternating -> exact, no wrap.
//  6 Reset mid-operation: dac_rst_i during STOP at dac_o=600
//    -> next cycle dac_o=0, active_o=0, clip_o=0, state IDLE.

Source files
------------

// File: rtl/red_pitaya_dac_pkg.sv
// rtl/red_pitaya_dac_pkg.sv - shared types, widths and clamp helper for the DAC slew limiter
package red_pitaya_dac_pkg;

    localparam int DAC_DW = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } slew_state_t;

    // Lower bound applied first, upper bound last, so an inverted window yields hi.
    function automatic logic signed [DAC_DW-1:0] sat_clamp(
        input logic signed [DAC_DW-1:0] x,
        input logic signed [DAC_DW-1:0] lo,
        input logic signed [DAC_DW-1:0] hi
    );
        logic signed [DAC_DW-1:0] r;
        r = (x < lo) ? lo : x;
        r = (r > hi) ? hi : r;
        return r;
    endfunction

endpackage

// File: rtl/red_pitaya_dac_slew_lim_if.sv
// rtl/red_pitaya_dac_slew_lim_if.sv - per-channel sample, config and status bundle
interface red_pitaya_dac_slew_lim_if
    import red_pitaya_dac_pkg::*;
#(
    parameter int DW = DAC_DW
);
    logic signed [DW-1:0] dat_i;
    logic                 enable_i;
    logic        [DW-1:0] slew_step_i;
    logic signed [DW-1:0] clip_hi_i;
    logic signed [DW-1:0] clip_lo_i;
    logic                 clr_i;
    logic signed [DW-1:0] dac_o;
    logic                 active_o;
    logic                 slewing_o;
    logic                 clip_o;

    modport slave (
        input  dat_i, enable_i, slew_step_i, clip_hi_i, clip_lo_i, clr_i,
        output dac_o, active_o, slewing_o, clip_o
    );

    modport master (
        output dat_i, enable_i, slew_step_i, clip_hi_i, clip_lo_i, clr_i,
        input  dac_o, active_o, slewing_o, clip_o
    );
endinterface

// File: rtl/red_pitaya_dac_clip.sv
// rtl/red_pitaya_dac_clip.sv - stage-1 clamp register with clip event flag
module red_pitaya_dac_clip
    import red_pitaya_dac_pkg::*;
#(
    parameter int DW = DAC_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic signed [DW-1:0] clip_hi_i,
    input  logic signed [DW-1:0] clip_lo_i,
    output logic signed [DW-1:0] tgt_o,
    output logic                 clip_ev_o
);
    logic signed [DW-1:0] tgt_q, tgt_d;
    logic                 clip_ev_q, clip_ev_d;

    // Clamp the incoming sample against the live window.
    always_comb begin
        tgt_d     = sat_clamp(dat_i, clip_lo_i, clip_hi_i);
        clip_ev_d = (tgt_d != dat_i);
    end

    // Register the clamped target and its clip event together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_q     <= '0;
            clip_ev_q <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            clip_ev_q <= clip_ev_d;
        end
    end

    assign tgt_o     = tgt_q;
    assign clip_ev_o = clip_ev_q;
endmodule

// File: rtl/red_pitaya_dac_slew_lim.sv
// rtl/red_pitaya_dac_slew_lim.sv - DAC output clamp, slew limiter and ramp-down sequencer
module red_pitaya_dac_slew_lim
    import red_pitaya_dac_pkg::*;
#(
    parameter int DW = DAC_DW
) (
    input  logic                      dac_clk_i,
    input  logic                      dac_rst_i,
    red_pitaya_dac_slew_lim_if.slave  ch
);
    logic signed [DW-1:0] tgt;
    logic                 clip_ev;

    slew_state_t          state_q, state_d;
    logic        [DW-1:0] dac_q, dac_d;
    logic                 slewing_q, slewing_d;
    logic                 active_q, active_d;
    logic                 clip_q, clip_d;

    logic        [DW-1:0] tgt_eff;
    logic        [DW:0]   diff, mag, step_ext, stepped;

    red_pitaya_dac_clip #(.DW(DW)) u_clip (
        .clk_i     (dac_clk_i),
        .rst_i     (dac_rst_i),
        .dat_i     (ch.dat_i),
        .clip_hi_i (ch.clip_hi_i),
        .clip_lo_i (ch.clip_lo_i),
        .tgt_o     (tgt),
        .clip_ev_o (clip_ev)
    );

    // Slew arithmetic: one extra bit so target minus output never overflows.
    always_comb begin
        tgt_eff   = (state_q == RUN) ? tgt : '0;
        diff      = {tgt_eff[DW-1], tgt_eff} - {dac_q[DW-1], dac_q};
        mag       = diff[DW] ? (~diff + 1'b1) : diff;
        step_ext  = {1'b0, ch.slew_step_i};
        stepped   = {dac_q[DW-1], dac_q} + (diff[DW] ? (~step_ext + 1'b1) : step_ext);
        dac_d     = tgt_eff;
        slewing_d = 1'b0;
        if (ch.slew_step_i != '0 && mag > step_ext) begin
            dac_d     = stepped[DW-1:0];
            slewing_d = 1'b1;
        end
        if (state_q == IDLE) begin
            dac_d     = '0;
            slewing_d = 1'b0;
        end
    end

    // Run/stop sequencing; STOP exits to IDLE only once the output has reached zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ch.enable_i) state_d = RUN;
            RUN:     if (!ch.enable_i) state_d = STOP;
            STOP: begin
                if (ch.enable_i)        state_d = RUN;
                else if (dac_q == '0)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
        // Set beats clear when both land in the same cycle.
        if (clip_ev && state_q == RUN) clip_d = 1'b1;
        else if (ch.clr_i)             clip_d = 1'b0;
        else                           clip_d = clip_q;
    end

    // State, output sample and status registers.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q   <= IDLE;
            dac_q     <= '0;
            slewing_q <= 1'b0;
            active_q  <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dac_q     <= dac_d;
            slewing_q <= slewing_d;
            active_q  <= active_d;
            clip_q    <= clip_d;
        end
    end

    assign ch.dac_o     = dac_q;
    assign ch.active_o  = active_q;
    assign ch.slewing_o = slewing_q;
    assign ch.clip_o    = clip_q;
endmodule

// File: tb/tb_red_pitaya_dac_slew_lim.sv
// tb/tb_red_pitaya_dac_slew_lim.sv - directed self-checking bench for the DAC slew limiter
module tb_red_pitaya_dac_slew_lim;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic signed [13:0] e14;

    red_pitaya_dac_slew_lim_if #(.DW(14)) ch ();

    red_pitaya_dac_slew_lim #(.DW(14)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .ch        (ch)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch.enable_i = 1'b0;
        ch.clr_i = 1'b0;
        ch.dat_i = '0;
        tick();
        tick();
        rst = 1'b0;
        ch.slew_step_i = '0;
        ch.clip_lo_i = 14'(-8192);
        ch.clip_hi_i = 14'(8191);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(1234);
        tick();
        tick();
        n_vec++; if (ch.dac_o !== 14'd0) begin n_err++; $display("FAIL reset dac: got %0d want 0", $signed(ch.dac_o)); end
        n_vec++; if (ch.active_o !== 1'b0) begin n_err++; $display("FAIL reset active: got %b want 0", ch.active_o); end
        n_vec++; if (ch.slewing_o !== 1'b0) begin n_err++; $display("FAIL reset slewing: got %b want 0", ch.slewing_o); end
        n_vec++; if (ch.clip_o !== 1'b0) begin n_err++; $display("FAIL reset clip: got %b want 0", ch.clip_o); end
    endtask

    task automatic test_bypass();
        int v [4];
        v[0] = 3; v[1] = 30; v[2] = 8000; v[3] = -4;
        do_reset();
        ch.enable_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ch.dat_i = 14'(v[(k < 4) ? k : 3]);
            tick();
            if (k >= 1) begin
                e14 = 14'(v[k-1]);
                n_vec++; if (ch.dac_o !== e14) begin n_err++; $display("FAIL bypass dac[%0d]: got %0d want %0d", k, $signed(ch.dac_o), e14); end
                n_vec++; if (ch.slewing_o !== 1'b0) begin n_err++; $display("FAIL bypass slewing[%0d]: got %b want 0", k, ch.slewing_o); end
                n_vec++; if (ch.clip_o !== 1'b0) begin n_err++; $display("FAIL bypass clip[%0d]: got %b want 0", k, ch.clip_o); end
            end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        ch.clip_hi_i = 14'(2000);
        ch.clip_lo_i = 14'(-2000);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(8000);
        tick(); tick();
        n_vec++; if (ch.dac_o !== 14'(2000)) begin n_err++; $display("FAIL clamp hi dac: got %0d want 2000", $signed(ch.dac_o)); end
        n_vec++; if (ch.clip_o !== 1'b1) begin n_err++; $display("FAIL clamp hi clip: got %b want 1", ch.clip_o); end
        ch.dat_i = 14'(-8000);
        tick(); tick();
        n_vec++; if (ch.dac_o !== 14'(-2000)) begin n_err++; $display("FAIL clamp lo dac: got %0d want -2000", $signed(ch.dac_o)); end
        ch.dat_i = 14'(0);
        tick(); tick();
        n_vec++; if (ch.clip_o !== 1'b1) begin n_err++; $display("FAIL clamp sticky: got %b want 1", ch.clip_o); end
        ch.clr_i = 1'b1;
        tick();
        ch.clr_i = 1'b0;
        n_vec++; if (ch.clip_o !== 1'b0) begin n_err++; $display("FAIL clamp clear: got %b want 0", ch.clip_o); end
        ch.dat_i = 14'(8000);
        tick();
        n_vec++; if (ch.clip_o !== 1'b0) begin n_err++; $display("FAIL clamp pre-set: got %b want 0", ch.clip_o); end
        ch.clr_i = 1'b1;
        tick();
        ch.clr_i = 1'b0;
        n_vec++; if (ch.clip_o !== 1'b1) begin n_err++; $display("FAIL clamp set-wins: got %b want 1", ch.clip_o); end
    endtask

    task automatic test_slew();
        do_reset();
        ch.slew_step_i = 14'(100);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(1050);
        tick();
        for (int n = 1; n <= 11; n++) begin
            tick();
            e14 = (n <= 10) ? 14'(100 * n) : 14'(1050);
            n_vec++; if (ch.dac_o !== e14) begin n_err++; $display("FAIL slew dac[%0d]: got %0d want %0d", n, $signed(ch.dac_o), e14); end
            n_vec++; if (ch.slewing_o !== (n <= 10)) begin n_err++; $display("FAIL slew flag[%0d]: got %b want %b", n, ch.slewing_o, (n <= 10)); end
        end
    endtask

    task automatic test_rampdown();
        int r [5];
        r[0] = 1000; r[1] = 750; r[2] = 500; r[3] = 250; r[4] = 0;
        do_reset();
        ch.slew_step_i = 14'(250);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(1000);
        for (int k = 0; k < 6; k++) tick();
        n_vec++; if (ch.dac_o !== 14'(1000)) begin n_err++; $display("FAIL ramp settle: got %0d want 1000", $signed(ch.dac_o)); end
        ch.enable_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            e14 = 14'(r[k]);
            n_vec++; if (ch.dac_o !== e14) begin n_err++; $display("FAIL ramp dac[%0d]: got %0d want %0d", k, $signed(ch.dac_o), e14); end
            n_vec++; if (ch.active_o !== 1'b1) begin n_err++; $display("FAIL ramp active[%0d]: got %b want 1", k, ch.active_o); end
        end
        tick();
        n_vec++; if (ch.active_o !== 1'b0) begin n_err++; $display("FAIL ramp active-fall: got %b want 0", ch.active_o); end
        n_vec++; if (ch.dac_o !== 14'd0) begin n_err++; $display("FAIL ramp idle dac: got %0d want 0", $signed(ch.dac_o)); end
    endtask

    task automatic test_resume();
        int r [4];
        r[0] = 500; r[1] = 750; r[2] = 1000; r[3] = 1000;
        do_reset();
        ch.slew_step_i = 14'(250);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(1000);
        for (int k = 0; k < 6; k++) tick();
        ch.enable_i = 1'b0;
        tick();
        tick();
        n_vec++; if (ch.dac_o !== 14'(750)) begin n_err++; $display("FAIL resume pre: got %0d want 750", $signed(ch.dac_o)); end
        ch.enable_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            e14 = 14'(r[k]);
            n_vec++; if (ch.dac_o !== e14) begin n_err++; $display("FAIL resume dac[%0d]: got %0d want %0d", k, $signed(ch.dac_o), e14); end
            n_vec++; if (ch.active_o !== 1'b1) begin n_err++; $display("FAIL resume active[%0d]: got %b want 1", k, ch.active_o); end
        end
    endtask

    task automatic test_extremes();
        int alt [4];
        int s [4];
        alt[0] = -8192; alt[1] = 8191; alt[2] = -8192; alt[3] = 8191;
        do_reset();
        ch.clip_lo_i = 14'(100);
        ch.clip_hi_i = 14'(-100);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(0);
        tick(); tick();
        n_vec++; if (ch.dac_o !== 14'(-100)) begin n_err++; $display("FAIL inverted dac: got %0d want -100", $signed(ch.dac_o)); end
        n_vec++; if (ch.clip_o !== 1'b1) begin n_err++; $display("FAIL inverted clip: got %b want 1", ch.clip_o); end
        ch.dat_i = 14'(-5000);
        tick(); tick();
        n_vec++; if (ch.dac_o !== 14'(-100)) begin n_err++; $display("FAIL inverted neg dac: got %0d want -100", $signed(ch.dac_o)); end

        do_reset();
        ch.slew_step_i = 14'(16383);
        ch.enable_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ch.dat_i = 14'(alt[(k < 4) ? k : 3]);
            tick();
            if (k >= 1) begin
                e14 = 14'(alt[k-1]);
                n_vec++; if (ch.dac_o !== e14) begin n_err++; $display("FAIL extreme dac[%0d]: got %0d want %0d", k, $signed(ch.dac_o), e14); end
                n_vec++; if (ch.slewing_o !== 1'b0) begin n_err++; $display("FAIL extreme slewing[%0d]: got %b want 0", k, ch.slewing_o); end
            end
        end

        do_reset();
        ch.slew_step_i = 14'(8000);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(8191);
        tick(); tick(); tick();
        n_vec++; if (ch.dac_o !== 14'(8191)) begin n_err++; $display("FAIL wide-step up: got %0d want 8191", $signed(ch.dac_o)); end
        ch.dat_i = 14'(-8192);
        s[0] = 8191; s[1] = 191; s[2] = -7809; s[3] = -8192;
        for (int k = 0; k < 4; k++) begin
            tick();
            e14 = 14'(s[k]);
            n_vec++; if (ch.dac_o !== e14) begin n_err++; $display("FAIL wide-step dac[%0d]: got %0d want %0d", k, $signed(ch.dac_o), e14); end
            n_vec++; if (ch.slewing_o !== (k == 1 || k == 2)) begin n_err++; $display("FAIL wide-step flag[%0d]: got %b want %b", k, ch.slewing_o, (k == 1 || k == 2)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ch.clip_hi_i = 14'(1000);
        ch.slew_step_i = 14'(200);
        ch.enable_i = 1'b1;
        ch.dat_i = 14'(5000);
        for (int k = 0; k < 7; k++) tick();
        n_vec++; if (ch.clip_o !== 1'b1) begin n_err++; $display("FAIL midrst clip pre: got %b want 1", ch.clip_o); end
        ch.enable_i = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (ch.dac_o !== 14'(600)) begin n_err++; $display("FAIL midrst dac pre: got %0d want 600", $signed(ch.dac_o)); end
        n_vec++; if (ch.slewing_o !== 1'b1) begin n_err++; $display("FAIL midrst slewing pre: got %b want 1", ch.slewing_o); end
        rst = 1'b1;
        tick();
        n_vec++; if (ch.dac_o !== 14'd0) begin n_err++; $display("FAIL midrst dac: got %0d want 0", $signed(ch.dac_o)); end
        n_vec++; if (ch.active_o !== 1'b0) begin n_err++; $display("FAIL midrst active: got %b want 0", ch.active_o); end
        n_vec++; if (ch.clip_o !== 1'b0) begin n_err++; $display("FAIL midrst clip: got %b want 0", ch.clip_o); end
        n_vec++; if (ch.slewing_o !== 1'b0) begin n_err++; $display("FAIL midrst slewing: got %b want 0", ch.slewing_o); end
        rst = 1'b0;
        tick();
        n_vec++; if (ch.dac_o !== 14'd0) begin n_err++; $display("FAIL midrst idle dac: got %0d want 0", $signed(ch.dac_o)); end
        n_vec++; if (ch.active_o !== 1'b0) begin n_err++; $display("FAIL midrst idle active: got %b want 0", ch.active_o); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ch.dat_i = '0;
        ch.enable_i = 1'b0;
        ch.slew_step_i = '0;
        ch.clip_hi_i = 14'(8191);
        ch.clip_lo_i = 14'(-8192);
        ch.clr_i = 1'b0;
        test_reset();
        test_bypass();
        test_clamp();
        test_slew();
        test_rampdown();
        test_resume();
        test_extremes();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
